// File: rtl/sqrt_pkg.sv
// Shared constants for the integer square-root unit and its checker.
package sqrt_pkg;

  localparam int unsigned SQRT_VW = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_CMP  = 2'd2;

endpackage

// File: rtl/seq_shift_add_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, VW cycles after start.
module seq_shift_add_mul #(
  parameter int unsigned VW = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_start,
  input  logic [VW-1:0]   i_mcand,
  input  logic [VW-1:0]   i_mplier,
  output logic            o_last_c,
  output logic [2*VW-1:0] o_product
);

  localparam int unsigned PW = 2 * VW;
  localparam int unsigned CW = (VW > 1) ? $clog2(VW) : 1;

  logic [PW-1:0] r_mcand;
  logic [VW-1:0] r_mplier;
  logic [PW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_run;
  logic [PW-1:0] w_partial;

  assign w_partial = r_mplier[r_cnt] ? (r_mcand << r_cnt) : '0;
  // Asserted during the cycle whose edge performs the final partial-product add.
  assign o_last_c  = r_run && (r_cnt == CW'(VW - 1));
  assign o_product = r_acc;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= PW'(i_mcand);
      r_mplier <= i_mplier;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b1;
    end else if (r_run) begin
      r_acc <= r_acc + w_partial;
      r_cnt <= r_cnt + CW'(1);
      if (o_last_c) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/sqrt_check.sv
// Verifies a candidate floor square root: squares root_in and checks root^2 <= value < (root+1)^2.
module sqrt_check
  import sqrt_pkg::*;
#(
  parameter int unsigned VW = SQRT_VW
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start_in,
  input  logic [VW-1:0]   root_in,
  input  logic [VW-1:0]   value_in,
  output logic            busy,
  output logic            done,
  output logic [2*VW-1:0] square_out,
  output logic            pass
);

  localparam int unsigned PW = 2 * VW;
  localparam int unsigned UW = 2 * VW + 1;

  logic [1:0]    r_state, w_state_nxt;
  logic [VW-1:0] r_root, w_root_nxt;
  logic [VW-1:0] r_val, w_val_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_pass, w_pass_nxt;
  logic [PW-1:0] r_square, w_square_nxt;

  logic          w_mul_start;
  logic          w_mul_last;
  logic [PW-1:0] w_prod;
  logic [UW-1:0] w_upper;
  logic [UW-1:0] w_val_ext;
  logic          w_in_range;

  assign w_mul_start = (r_state == S_IDLE) && start_in;

  seq_shift_add_mul #(.VW(VW)) u_mul (
    .clock     (clock),
    .reset     (reset),
    .i_start   (w_mul_start),
    .i_mcand   (root_in),
    .i_mplier  (root_in),
    .o_last_c  (w_mul_last),
    .o_product (w_prod)
  );

  // Upper bound carries one extra bit so root = 2^VW-1 cannot wrap.
  assign w_upper    = UW'(w_prod) + (UW'(r_root) << 1) + UW'(1);
  assign w_val_ext  = UW'(r_val);
  assign w_in_range = (w_val_ext >= UW'(w_prod)) && (w_val_ext < w_upper);

  always_comb begin
    w_state_nxt  = r_state;
    w_root_nxt   = r_root;
    w_val_nxt    = r_val;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_pass_nxt   = r_pass;
    w_square_nxt = r_square;
    case (r_state)
      S_IDLE: begin
        if (start_in) begin
          w_root_nxt  = root_in;
          w_val_nxt   = value_in;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        if (w_mul_last) w_state_nxt = S_CMP;
      end
      S_CMP: begin
        w_square_nxt = w_prod;
        w_pass_nxt   = w_in_range;
        w_done_nxt   = 1'b1;
        w_busy_nxt   = 1'b0;
        w_state_nxt  = S_IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_root   <= '0;
      r_val    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_square <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_root   <= w_root_nxt;
      r_val    <= w_val_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_pass   <= w_pass_nxt;
      r_square <= w_square_nxt;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign square_out = r_square;

endmodule

// File: tb/tb_sqrt_check.sv
// Self-checking bench for sqrt_check: directed cases plus randomized roots against an arithmetic model.
module tb_sqrt_check;

  localparam int unsigned VW = 8;

  logic          clock;
  logic          reset;
  logic          start_in;
  logic [VW-1:0] root_in;
  logic [VW-1:0] value_in;
  logic          busy;
  logic          done;
  logic [15:0]   square_out;
  logic          pass;

  int n_checks;
  int n_errors;

  sqrt_check #(.VW(VW)) dut (
    .clock      (clock),
    .reset      (reset),
    .start_in   (start_in),
    .root_in    (root_in),
    .value_in   (value_in),
    .busy       (busy),
    .done       (done),
    .square_out (square_out),
    .pass       (pass)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit model_pass(input int r, input int v);
    return (r * r <= v) && (v < (r + 1) * (r + 1));
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one check (caller sits just after an edge) and wait for its done pulse.
  task automatic run_one(input int r, input int v);
    int n;
    int nbusy;
    start_in = 1'b1;
    root_in  = VW'(r);
    value_in = VW'(v);
    tick();
    start_in = 1'b0;
    root_in  = VW'($urandom);
    value_in = VW'($urandom);
    n = 0;
    nbusy = busy ? 1 : 0;
    while (!done && n < 20) begin
      tick();
      n++;
      if (!done && busy) nbusy++;
    end
    check("latency", n, 9);
    check("busy_cycles", nbusy, 9);
    check("busy_at_done", busy, 0);
    check("square", square_out, r * r);
    check("pass", pass, model_pass(r, v));
  endtask

  // Watch for a given number of cycles and count any done pulses.
  task automatic count_done(input int cycles, output int dones);
    dones = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) dones++;
    end
  endtask

  initial begin
    int dones;
    int r;
    int v;
    int idle_bad;
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    start_in = 1'b0;
    root_in  = '0;
    value_in = '0;
    repeat (3) tick();
    reset = 1'b0;

    idle_bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done || busy || pass || square_out != 16'd0) idle_bad++;
    end
    check("reset_idle", idle_bad, 0);
    check("reset_square", square_out, 0);

    run_one(15, 255);
    tick();
    // Back-to-back: each new start is raised in the done cycle.
    run_one(5, 35);
    run_one(5, 36);
    run_one(6, 36);
    run_one(0, 0);
    run_one(255, 255);
    run_one(16, 255);
    run_one(255, 0);
    tick();

    // Start pulse while busy is ignored.
    start_in = 1'b1; root_in = 8'd3; value_in = 8'd9;
    tick();
    start_in = 1'b0;
    repeat (2) tick();
    start_in = 1'b1; root_in = 8'd7; value_in = 8'd1;
    tick();
    start_in = 1'b0;
    count_done(6, dones);
    check("ignore_done_count", dones, 1);
    check("ignore_square", square_out, 9);
    check("ignore_pass", pass, 1);
    count_done(12, dones);
    check("ignore_no_second_done", dones, 0);

    // Reset mid-operation aborts with no done pulse.
    start_in = 1'b1; root_in = 8'd10; value_in = 8'd100;
    tick();
    start_in = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_square", square_out, 0);
    check("abort_pass", pass, 0);
    count_done(12, dones);
    check("abort_no_done", dones, 0);
    run_one(10, 100);

    // Randomized: mostly values near the root's square boundaries.
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        v = int'($urandom_range(0, 255));
      end else begin
        r = int'($urandom_range(0, 15));
        v = r * r + int'($urandom_range(0, 2 * r + 2)) - 1;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
      end
      run_one(r, v);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
